// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with per-register pending bits; optional REGFILE_BYPASS_EN write-through.
// Latency: reads 0 cycles, write/reserve/pend_cnt 1 cycle; no backpressure, decode stalls on rd_busy.
module regfile_scoreboard #(
  parameter int DW      = 8,
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [DW-1:0] rd_data0,
  output logic [DW-1:0] rd_data1,
  output logic          rd_busy0,
  output logic          rd_busy1,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  output logic [AW:0]   pend_cnt,
  output logic          err_rsv
);

  localparam logic [AW:0] CNT_ONE = 1;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pend;
  logic            wr_act;
  logic            rsv_act;
  logic            same_addr;
  logic            cnt_inc;
  logic            cnt_dec;

  // Under ZERO_R0 any access to register 0 is dropped before it touches state.
  assign wr_act    = wr_en  && !((ZERO_R0 != 0) && (wr_addr  == '0));
  assign rsv_act   = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));
  assign same_addr = wr_act && rsv_act && (wr_addr == rsv_addr);

  // Same-address write+reserve retires one op and starts another: pending count unchanged if already set.
  assign cnt_inc = rsv_act && !pend[rsv_addr];
  assign cnt_dec = wr_act && pend[wr_addr] && !same_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
      err_rsv  <= 1'b0;
    end else begin
      if (wr_act) begin
        regs[wr_addr] <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      if (rsv_act) pend[rsv_addr] <= 1'b1;
      if (cnt_inc && !cnt_dec)      pend_cnt <= pend_cnt + CNT_ONE;
      else if (cnt_dec && !cnt_inc) pend_cnt <= pend_cnt - CNT_ONE;
      if (rsv_act && pend[rsv_addr] && !same_addr) err_rsv <= 1'b1;
    end
  end

  always_comb begin
    rd_data0 = regs[rd_addr0];
    rd_busy0 = pend[rd_addr0];
    rd_data1 = regs[rd_addr1];
    rd_busy1 = pend[rd_addr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_act && (wr_addr == rd_addr0)) begin
      rd_data0 = wr_data;
      rd_busy0 = rsv_act && (rsv_addr == rd_addr0);
    end
    if (wr_act && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
      rd_busy1 = rsv_act && (rsv_addr == rd_addr1);
    end
`endif
    if ((ZERO_R0 != 0) && (rd_addr0 == '0)) begin
      rd_data0 = '0;
      rd_busy0 = 1'b0;
    end
    if ((ZERO_R0 != 0) && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
  end

endmodule
